// File: rtl/regfile_pkg.sv
// Shared types and default widths for the register-file write arbiter.
package regfile_pkg;

   localparam int unsigned NREQ_DEF     = 3;
   localparam int unsigned ADDR_W_DEF   = 3;
   localparam int unsigned DATA_W_DEF   = 8;
   localparam int unsigned MAX_LOCK_DEF = 4;

   typedef enum logic [0:0] {
      StArb    = 1'b0,
      StLocked = 1'b1
   } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority pick: one-hot grant of the first valid bit at or after the pointer.
module rr_pick
   import regfile_pkg::*;
#(
   parameter int unsigned NREQ  = NREQ_DEF,
   parameter int unsigned PTR_W = $clog2(NREQ_DEF)
) (
   input  logic [NREQ-1:0]  i_valid,
   input  logic [PTR_W-1:0] i_ptr,
   output logic [NREQ-1:0]  o_grant
);

   logic [NREQ-1:0] w_mask;
   logic [NREQ-1:0] w_hi;
   logic [NREQ-1:0] w_src;

   // Prefer requesters at or above the pointer; wrap to the full vector if none of them is valid.
   always_comb begin
      w_mask = '0;
      for (int i = 0; i < NREQ; i++) begin
         w_mask[i] = (PTR_W'(i) >= i_ptr);
      end
      w_hi    = i_valid & w_mask;
      w_src   = (|w_hi) ? w_hi : i_valid;
      // Isolate the lowest set bit.
      o_grant = w_src & (~w_src + NREQ'(1));
   end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates NREQ write requesters onto the single register-file write port, with
// round-robin fairness and bounded burst locking.
module regfile_write_arbiter
   import regfile_pkg::*;
#(
   parameter int unsigned NREQ     = NREQ_DEF,
   parameter int unsigned ADDR_W   = ADDR_W_DEF,
   parameter int unsigned DATA_W   = DATA_W_DEF,
   parameter int unsigned MAX_LOCK = MAX_LOCK_DEF
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NREQ-1:0]            req_valid,
   input  logic [NREQ-1:0]            req_lock,
   input  logic [NREQ*ADDR_W-1:0]     req_address,
   input  logic [NREQ*DATA_W-1:0]     req_data,
   output logic [NREQ-1:0]            req_ready,
   output logic                       write_enable,
   output logic [ADDR_W-1:0]          write_address,
   output logic [DATA_W-1:0]          write_data,
   output logic [$clog2(NREQ)-1:0]    last_grant,
   output logic                       locked
);

   localparam int unsigned PTR_W  = $clog2(NREQ);
   localparam int unsigned BEAT_W = $clog2(MAX_LOCK + 1);

   arb_state_e        r_state, w_state_d;
   logic [PTR_W-1:0]  r_ptr, w_ptr_d;
   logic [PTR_W-1:0]  r_owner, w_owner_d;
   logic [BEAT_W-1:0] r_beat, w_beat_d;
   logic              r_we;
   logic [ADDR_W-1:0] r_waddr;
   logic [DATA_W-1:0] r_wdata;
   logic [PTR_W-1:0]  r_last;

   logic [NREQ-1:0]   w_pick;
   logic [NREQ-1:0]   w_grant;
   logic [NREQ-1:0]   w_owner_oh;
   logic [PTR_W-1:0]  w_gidx;
   logic [ADDR_W-1:0] w_sel_addr;
   logic [DATA_W-1:0] w_sel_data;
   logic              w_xfer;
   logic              w_xfer_lock;
   logic              w_owner_valid;
   logic [BEAT_W-1:0] w_beat_inc;
   logic              w_exit;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] v);
      if (v == PTR_W'(NREQ - 1)) begin
         return '0;
      end
      return v + 1'b1;
   endfunction

   rr_pick #(
      .NREQ  (NREQ),
      .PTR_W (PTR_W)
   ) u_rr_pick (
      .i_valid (req_valid),
      .i_ptr   (r_ptr),
      .o_grant (w_pick)
   );

   // Grant vector, granted index and the granted requester's address/data.
   always_comb begin
      w_owner_oh = '0;
      for (int i = 0; i < NREQ; i++) begin
         w_owner_oh[i] = (r_owner == PTR_W'(i));
      end
      // While locked only the owner can be served, and only if it is requesting.
      w_grant    = (r_state == StLocked) ? (req_valid & w_owner_oh) : w_pick;
      w_gidx     = '0;
      w_sel_addr = '0;
      w_sel_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_grant[i]) begin
            w_gidx     = PTR_W'(i);
            w_sel_addr = req_address[i*ADDR_W +: ADDR_W];
            w_sel_data = req_data[i*DATA_W +: DATA_W];
         end
      end
      w_xfer        = |w_grant;
      w_xfer_lock   = |(w_grant & req_lock);
      w_owner_valid = |(req_valid & w_owner_oh);
      w_beat_inc    = r_beat + 1'b1;
   end

   // Next-state logic for the ARB/LOCKED FSM, pointer, owner and beat counter.
   always_comb begin
      w_state_d = r_state;
      w_ptr_d   = r_ptr;
      w_owner_d = r_owner;
      w_beat_d  = r_beat;
      w_exit    = 1'b0;
      unique case (r_state)
         StArb: begin
            if (w_xfer) begin
               w_ptr_d = ptr_inc(w_gidx);
               // With MAX_LOCK of 1 a lock could never take a second beat, so stay in ARB.
               if (w_xfer_lock && (MAX_LOCK > 1)) begin
                  w_state_d = StLocked;
                  w_owner_d = w_gidx;
                  w_beat_d  = BEAT_W'(1);
               end
            end
         end
         StLocked: begin
            if (!w_owner_valid) begin
               w_exit = 1'b1;
            end else if (w_xfer) begin
               if (!w_xfer_lock || (w_beat_inc == BEAT_W'(MAX_LOCK))) begin
                  w_exit = 1'b1;
               end else begin
                  w_beat_d = w_beat_inc;
               end
            end
         end
         default: begin
            w_state_d = StArb;
         end
      endcase
      if (w_exit) begin
         w_state_d = StArb;
         w_ptr_d   = ptr_inc(r_owner);
         w_beat_d  = '0;
      end
   end

   // FSM and arbitration state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= StArb;
         r_ptr   <= '0;
         r_owner <= '0;
         r_beat  <= '0;
      end else begin
         r_state <= w_state_d;
         r_ptr   <= w_ptr_d;
         r_owner <= w_owner_d;
         r_beat  <= w_beat_d;
      end
   end

   // Register-file write port: one-cycle strobe per transfer, address/data held otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_we    <= 1'b0;
         r_waddr <= '0;
         r_wdata <= '0;
         r_last  <= '0;
      end else begin
         r_we <= w_xfer;
         if (w_xfer) begin
            r_waddr <= w_sel_addr;
            r_wdata <= w_sel_data;
            r_last  <= w_gidx;
         end
      end
   end

   assign req_ready     = w_grant;
   assign write_enable  = r_we;
   assign write_address = r_waddr;
   assign write_data    = r_wdata;
   assign last_grant    = r_last;
   assign locked        = (r_state == StLocked);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter at default parameters.
module tb_regfile_write_arbiter;

   logic        clk;
   logic        rst_n;
   logic [2:0]  req_valid;
   logic [2:0]  req_lock;
   logic [8:0]  req_address;
   logic [23:0] req_data;
   logic [2:0]  req_ready;
   logic        write_enable;
   logic [2:0]  write_address;
   logic [7:0]  write_data;
   logic [1:0]  last_grant;
   logic        locked;

   int n_total = 0;
   int n_pass  = 0;

   regfile_write_arbiter #(
      .NREQ     (3),
      .ADDR_W   (3),
      .DATA_W   (8),
      .MAX_LOCK (4)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid     (req_valid),
      .req_lock      (req_lock),
      .req_address   (req_address),
      .req_data      (req_data),
      .req_ready     (req_ready),
      .write_enable  (write_enable),
      .write_address (write_address),
      .write_data    (write_data),
      .last_grant    (last_grant),
      .locked        (locked)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Grant sanity on every cycle out of reset.
   always @(negedge clk) begin
      if (rst_n) begin
         n_total++;
         if ($onehot0(req_ready) && ((req_ready & ~req_valid) == 3'b000)) begin
            n_pass++;
         end else begin
            $display("FAIL grant_sanity t=%0t req_ready=%b req_valid=%b", $time, req_ready,
                     req_valid);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_std_inputs();
      req_address = {3'd3, 3'd2, 3'd1};
      req_data    = {8'h33, 8'h22, 8'h11};
   endtask

   task automatic do_reset();
      rst_n       = 1'b0;
      req_valid   = 3'b000;
      req_lock    = 3'b000;
      req_address = '0;
      req_data    = '0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n       = 1'b0;
      req_valid   = 3'b000;
      req_lock    = 3'b000;
      req_address = '0;
      req_data    = '0;
      #3;
      n_total++;
      if ({write_enable, write_address, write_data, last_grant, locked, req_ready} !== '0) begin
         $display("FAIL reset_state we=%b addr=%0d data=%h last=%0d locked=%b ready=%b want all 0",
                  write_enable, write_address, write_data, last_grant, locked, req_ready);
      end else n_pass++;
      do_reset();
   endtask

   task automatic test_round_robin();
      logic [2:0] exp_rdy;
      do_reset();
      set_std_inputs();
      req_valid = 3'b111;
      #1;
      n_total++;
      if (write_enable !== 1'b0) $display("FAIL rr_no_early_write we=%b want 0", write_enable);
      else n_pass++;
      for (int i = 0; i < 6; i++) begin
         exp_rdy = 3'b001 << (i % 3);
         n_total++;
         if (req_ready !== exp_rdy) $display("FAIL rr_ready[%0d] got=%b want=%b", i, req_ready,
                                            exp_rdy);
         else n_pass++;
         step();
         n_total++;
         if (write_enable !== 1'b1 || write_address !== 3'((i % 3) + 1) ||
             last_grant !== 2'(i % 3)) begin
            $display("FAIL rr_write[%0d] we=%b addr=%0d last=%0d want we=1 addr=%0d last=%0d", i,
                     write_enable, write_address, last_grant, (i % 3) + 1, i % 3);
         end else n_pass++;
      end
      n_total++;
      if (write_data !== 8'h33) $display("FAIL rr_last_data got=%h want=33", write_data);
      else n_pass++;
      req_valid = 3'b000;
      step();
      n_total++;
      if (write_enable !== 1'b0 || write_address !== 3'd3 || write_data !== 8'h33) begin
         $display("FAIL rr_idle_hold we=%b addr=%0d data=%h want we=0 addr=3 data=33",
                  write_enable, write_address, write_data);
      end else n_pass++;
   endtask

   task automatic test_single();
      do_reset();
      req_address = {3'd0, 3'd5, 3'd0};
      req_data    = {8'h00, 8'hAA, 8'h00};
      req_valid   = 3'b010;
      #1;
      n_total++;
      if (req_ready !== 3'b010) $display("FAIL single_ready got=%b want=010", req_ready);
      else n_pass++;
      step();
      req_valid = 3'b000;
      n_total++;
      if (write_enable !== 1'b1 || write_address !== 3'd5 || write_data !== 8'hAA ||
          last_grant !== 2'd1) begin
         $display("FAIL single_write we=%b addr=%0d data=%h last=%0d want 1/5/AA/1",
                  write_enable, write_address, write_data, last_grant);
      end else n_pass++;
      step();
      n_total++;
      if (write_enable !== 1'b0 || write_address !== 3'd5 || write_data !== 8'hAA) begin
         $display("FAIL single_pulse we=%b addr=%0d data=%h want 0/5/AA", write_enable,
                  write_address, write_data);
      end else n_pass++;
   endtask

   task automatic test_lock_max();
      int         exp_g[9]  = '{0, 1, 2, 2, 2, 2, 0, 1, 2};
      logic       exp_lk[9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      logic [2:0] exp_rdy;
      do_reset();
      set_std_inputs();
      req_valid = 3'b111;
      req_lock  = 3'b100;
      #1;
      for (int k = 0; k < 9; k++) begin
         exp_rdy = 3'b001 << exp_g[k];
         n_total++;
         if (req_ready !== exp_rdy || locked !== exp_lk[k]) begin
            $display("FAIL lockmax_grant[%0d] ready=%b locked=%b want ready=%b locked=%b", k,
                     req_ready, locked, exp_rdy, exp_lk[k]);
         end else n_pass++;
         step();
         n_total++;
         if (write_enable !== 1'b1 || last_grant !== 2'(exp_g[k])) begin
            $display("FAIL lockmax_write[%0d] we=%b last=%0d want we=1 last=%0d", k,
                     write_enable, last_grant, exp_g[k]);
         end else n_pass++;
      end
      req_valid = 3'b000;
      req_lock  = 3'b000;
   endtask

   task automatic test_lock_drop();
      do_reset();
      set_std_inputs();
      req_valid = 3'b111;
      req_lock  = 3'b001;
      #1;
      for (int k = 0; k < 2; k++) begin
         n_total++;
         if (req_ready !== 3'b001 || locked !== (k == 1)) begin
            $display("FAIL drop_beat[%0d] ready=%b locked=%b want ready=001 locked=%0d", k,
                     req_ready, locked, k == 1);
         end else n_pass++;
         step();
      end
      req_valid = 3'b110;
      #1;
      n_total++;
      if (req_ready !== 3'b000 || locked !== 1'b1) begin
         $display("FAIL drop_cycle ready=%b locked=%b want 000/1", req_ready, locked);
      end else n_pass++;
      step();
      n_total++;
      if (write_enable !== 1'b0 || locked !== 1'b0 || req_ready !== 3'b010) begin
         $display("FAIL drop_exit we=%b locked=%b ready=%b want 0/0/010", write_enable, locked,
                  req_ready);
      end else n_pass++;
      step();
      req_valid = 3'b000;
      n_total++;
      if (write_enable !== 1'b1 || last_grant !== 2'd1 || write_address !== 3'd2) begin
         $display("FAIL drop_next we=%b last=%0d addr=%0d want 1/1/2", write_enable,
                  last_grant, write_address);
      end else n_pass++;
   endtask

   task automatic test_reset_mid_lock();
      do_reset();
      set_std_inputs();
      req_valid = 3'b100;
      req_lock  = 3'b100;
      #1;
      n_total++;
      if (req_ready !== 3'b100) $display("FAIL midrst_first ready=%b want=100", req_ready);
      else n_pass++;
      step();
      n_total++;
      if (locked !== 1'b1 || req_ready !== 3'b100 || write_enable !== 1'b1) begin
         $display("FAIL midrst_locked locked=%b ready=%b we=%b want 1/100/1", locked, req_ready,
                  write_enable);
      end else n_pass++;
      #2;
      rst_n = 1'b0;
      #1;
      n_total++;
      if (write_enable !== 1'b0 || locked !== 1'b0 || write_address !== 3'd0 ||
          write_data !== 8'h00 || last_grant !== 2'd0) begin
         $display("FAIL midrst_async we=%b locked=%b addr=%0d data=%h last=%0d want all 0",
                  write_enable, locked, write_address, write_data, last_grant);
      end else n_pass++;
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      req_valid = 3'b111;
      req_lock  = 3'b000;
      #1;
      n_total++;
      if (req_ready !== 3'b001 || write_enable !== 1'b0) begin
         $display("FAIL midrst_release ready=%b we=%b want 001/0", req_ready, write_enable);
      end else n_pass++;
      step();
      req_valid = 3'b000;
      n_total++;
      if (write_enable !== 1'b1 || last_grant !== 2'd0 || write_address !== 3'd1) begin
         $display("FAIL midrst_grant we=%b last=%0d addr=%0d want 1/0/1", write_enable,
                  last_grant, write_address);
      end else n_pass++;
      step();
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_single();
      test_lock_max();
      test_lock_drop();
      test_reset_mid_lock();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 3, number of write requesters sharing the register-file write port.
REQ-002 SHALL have parameter ADDR_W, default 3, register address width (8 registers).
REQ-003 SHALL have parameter DATA_W, default 8, register data width.
REQ-004 SHALL have parameter MAX_LOCK, default 4, maximum consecutive beats one locked requester may hold the port.
REQ-005 Port: clk  input  1  single clock, rising edge.
REQ-006 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-007 Port: req_valid  input  NREQ  per-requester write request.
REQ-008 Port: req_lock  input  NREQ  per-requester burst-lock request, sampled with req_valid.
REQ-009 Port: req_address  input  NREQ*ADDR_W  packed write addresses, requester i at bits [i*ADDR_W +: ADDR_W].
REQ-010 Port: req_data  input  NREQ*DATA_W  packed write data, same packing.
REQ-011 Port: req_ready  output  NREQ  one-hot-or-zero grant; transfer when req_valid[i] and req_ready[i].
REQ-012 Port: write_enable  output  1  register-file write strobe.
REQ-013 Port: write_address  output  ADDR_W  register-file write address.
REQ-014 Port: write_data  output  DATA_W  register-file write data.
REQ-015 Port: last_grant  output  clog2(NREQ)  index of requester of the most recent transfer.
REQ-016 Port: locked  output  1  high while FSM is in LOCKED.

Function
REQ-017 req_ready SHALL be combinational from FSM state, round-robin pointer and req_valid; at most one bit high; never high for a requester with req_valid low.
REQ-018 ARB state: grant the first valid requester searching from pointer, pointer, pointer+1, ... modulo NREQ; pointer SHALL become granted index+1 (mod NREQ) after each transfer.
REQ-019 No valid requester: req_ready=0, pointer unchanged, write_enable low next cycle.
REQ-020 Transfer in cycle N: write_enable=1, write_address/write_data = granted requester's values in cycle N+1 (latency 1); write_enable high exactly one cycle per transfer; maximum one write per cycle.
REQ-021 write_address/write_data SHALL hold their last values while write_enable is low.
REQ-022 Transfer with req_lock[i]=1 in ARB: FSM -> LOCKED, owner=i, beat counter=1.
REQ-023 LOCKED: only owner may be granted; each owner transfer with req_lock high increments beat counter.
REQ-024 LOCKED exit to ARB when owner drops req_valid, owner transfers with req_lock low, or beat counter reaches MAX_LOCK; pointer = owner+1 on exit.
REQ-025 After a MAX_LOCK exit, the owner SHALL be re-grantable only via normal ARB round-robin (other valid requesters served first).
REQ-026 Beat counter width SHALL hold MAX_LOCK without overflow; MAX_LOCK=1 degenerates to plain round-robin.
REQ-027 last_grant updates in cycle after each transfer, alongside write_enable.

Reset
REQ-028 rst_n low SHALL asynchronously force: state ARB, pointer 0, beat counter 0, write_enable 0, write_address 0, write_data 0, last_grant 0, locked 0.
REQ-029 A transfer in the cycle rst_n asserts SHALL be discarded (no write_enable after release).
REQ-030 First arbitration after reset release SHALL give requester 0 highest priority.

Structure
REQ-031 State encoding (ARB, LOCKED) and default widths SHALL live in shared package regfile_pkg.
REQ-032 Round-robin priority selection SHALL be a sub-module rr_pick (inputs: valid vector, pointer; output: one-hot grant).
REQ-033 Output of this block SHALL connect directly to the existing register file write port; read ports are untouched.

Verification
REQ-034 After reset, req_valid=3'b111, lock=0, addresses 1/2/3, data 8'h11/8'h22/8'h33 held 6 cycles -> writes addr 1,2,3,1,2,3, one per cycle, starting one cycle after first grant.
REQ-035 req_valid=3'b010 only, addr 5, data 8'hAA -> req_ready=3'b010, write_enable pulse addr 5 data 8'hAA, last_grant=1.
REQ-036 Requester 2 valid+lock continuously, requesters 0/1 valid -> requester 2 granted 4 consecutive beats (MAX_LOCK), locked=1, then 0 and 1 served before 2 again.
REQ-037 Locked owner drops req_valid after 2 beats -> locked=0 next cycle, next-in-rotation requester granted.
REQ-038 rst_n pulsed low mid-lock with transfer pending -> write_enable=0 immediately, locked=0, next grant goes to requester 0.
REQ-039 Bench SHALL assert every cycle: $onehot0(req_ready) and req_ready subset of req_valid.
